// File: rtl/write_back_stage_pkg.sv
// Shared constants for the write-back stage: opcodes, FSM state and load-mode encodings.
// Opcode helpers keep instruction decoding in one place.
package write_back_stage_pkg;

    localparam logic [5:0] OP_LD = 6'h20;
    localparam logic [5:0] OP_LH = 6'h21;
    localparam logic [5:0] OP_LW = 6'h23;
    localparam logic [5:0] OP_SD = 6'h28;
    localparam logic [5:0] OP_SH = 6'h29;
    localparam logic [5:0] OP_SW = 6'h2B;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_WAIT_LD = 1'b1
    } wb_state_t;

    // Same encoding as the memory stage's data_mode.
    typedef enum logic [1:0] {
        MODE_WORD = 2'd0,
        MODE_HALF = 2'd1,
        MODE_BYTE = 2'd2
    } ld_mode_t;

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_LH) || (op == OP_LD);
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SD);
    endfunction

    function automatic ld_mode_t mode_of(input logic [5:0] op);
        case (op)
            OP_LH:   return MODE_HALF;
            OP_LD:   return MODE_BYTE;
            default: return MODE_WORD;
        endcase
    endfunction

endpackage

// File: rtl/write_back_stage_load_align.sv
// Combinational load extraction: word pass-through, half sign-extended, byte zero-extended.
// Zero latency, no flow control.
module load_align
    import write_back_stage_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  ld_mode_t           i_mode,
    input  logic [WIDTH-1:0]   i_mem_data,
    output logic [WIDTH-1:0]   o_data
);

    always_comb begin
        o_data = i_mem_data;
        case (i_mode)
            MODE_HALF: o_data = {{(WIDTH-16){i_mem_data[15]}}, i_mem_data[15:0]};
            MODE_BYTE: o_data = {{(WIDTH-8){1'b0}}, i_mem_data[7:0]};
            default:   o_data = i_mem_data;
        endcase
    end

endmodule

// File: rtl/write_back_stage.sv
// Write-back stage: one registered register-file write per retiring instruction, load wait with timeout.
// Latency: 1 cycle after capture; stalls upstream combinationally while a load waits for mem_rd_st.
module write_back_stage
    import write_back_stage_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_in,
    input  logic [WIDTH-1:0]   instruction_in,
    input  logic [WIDTH-3:0]   progcounter_in,
    input  logic [WIDTH-1:0]   dataC_in,
    input  logic [WIDTH-1:0]   mem_data,
    input  logic               mem_rd_st,
    output logic               stall_out,
    output logic               rf_we,
    output logic [4:0]         rf_waddr,
    output logic [WIDTH-1:0]   rf_wdata,
    output logic [WIDTH-3:0]   retired_pc,
    output logic [31:0]        retire_count,
    output logic               mem_err
);

    localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

    wb_state_t          r_state;
    logic [7:0]         r_cnt;
    logic [4:0]         r_ld_rd;
    logic [WIDTH-3:0]   r_ld_pc;
    ld_mode_t           r_ld_mode;

    logic               r_cap_vld;
    logic               r_cap_we;
    logic [4:0]         r_cap_waddr;
    logic [WIDTH-1:0]   r_cap_wdata;
    logic [WIDTH-3:0]   r_cap_pc;

    logic               r_rf_we;
    logic [4:0]         r_rf_waddr;
    logic [WIDTH-1:0]   r_rf_wdata;
    logic [WIDTH-3:0]   r_retired_pc;
    logic [31:0]        r_retire_count;
    logic               r_mem_err;

    logic [5:0]         w_op;
    logic [4:0]         w_rd;
    logic               w_is_load;
    logic               w_is_store;
    logic               w_is_nop;
    ld_mode_t           w_align_mode;
    logic [WIDTH-1:0]   w_ld_data;

    assign w_op         = instruction_in[31:26];
    assign w_rd         = instruction_in[25:21];
    assign w_is_load    = is_load(w_op);
    assign w_is_store   = is_store(w_op);
    assign w_is_nop     = (instruction_in == '0);
    assign w_align_mode = (r_state == ST_IDLE) ? mode_of(w_op) : r_ld_mode;

    load_align #(.WIDTH(WIDTH)) u_align (
        .i_mode     (w_align_mode),
        .i_mem_data (mem_data),
        .o_data     (w_ld_data)
    );

    assign stall_out = ((r_state == ST_IDLE) && valid_in && w_is_load && !mem_rd_st) ||
                       ((r_state == ST_WAIT_LD) && !mem_rd_st);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_ld_rd        <= '0;
            r_ld_pc        <= '0;
            r_ld_mode      <= MODE_WORD;
            r_cap_vld      <= 1'b0;
            r_cap_we       <= 1'b0;
            r_cap_waddr    <= '0;
            r_cap_wdata    <= '0;
            r_cap_pc       <= '0;
            r_rf_we        <= 1'b0;
            r_rf_waddr     <= '0;
            r_rf_wdata     <= '0;
            r_retired_pc   <= '0;
            r_retire_count <= '0;
            r_mem_err      <= 1'b0;
        end else begin
            // Output stage: publish whatever was captured on the previous edge.
            r_rf_we   <= r_cap_vld && r_cap_we;
            r_mem_err <= 1'b0;
            if (r_cap_vld && r_cap_we) begin
                r_rf_waddr <= r_cap_waddr;
                r_rf_wdata <= r_cap_wdata;
            end
            if (r_cap_vld) begin
                r_retired_pc   <= r_cap_pc;
                r_retire_count <= r_retire_count + 32'd1;
            end

            r_cap_vld <= 1'b0;
            r_cap_we  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (valid_in) begin
                        if (w_is_load && !mem_rd_st) begin
                            r_state   <= ST_WAIT_LD;
                            r_cnt     <= '0;
                            r_ld_rd   <= w_rd;
                            r_ld_pc   <= progcounter_in;
                            r_ld_mode <= mode_of(w_op);
                        end else begin
                            r_cap_vld   <= 1'b1;
                            r_cap_we    <= (w_rd != 5'd0) && !w_is_store && !w_is_nop;
                            r_cap_waddr <= w_rd;
                            r_cap_wdata <= w_is_load ? w_ld_data : dataC_in;
                            r_cap_pc    <= progcounter_in;
                        end
                    end
                end
                ST_WAIT_LD: begin
                    if (mem_rd_st) begin
                        r_state     <= ST_IDLE;
                        r_cap_vld   <= 1'b1;
                        r_cap_we    <= (r_ld_rd != 5'd0);
                        r_cap_waddr <= r_ld_rd;
                        r_cap_wdata <= w_ld_data;
                        r_cap_pc    <= r_ld_pc;
                    end else if (r_cnt == LP_LAST) begin
                        r_state   <= ST_IDLE;
                        r_mem_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rf_we        = r_rf_we;
    assign rf_waddr     = r_rf_waddr;
    assign rf_wdata     = r_rf_wdata;
    assign retired_pc   = r_retired_pc;
    assign retire_count = r_retire_count;
    assign mem_err      = r_mem_err;

endmodule
